// File: rtl/venda_if.sv
// ---------------------------------------------------------------------------
// venda_if: request/response bundle of the vending sequencer.
//   master : keypad/coin side (drives the strobes, observes the outputs)
//   slave  : controlador_venda (consumes the strobes, drives the outputs)
// Signals:
//   sel_valida/sel_produto   product selection strobe + index 0..3
//   moeda_valida/moeda_valor coin strobe + value 1..15 (0 ignored)
//   cancelar                 user abort strobe
//   total, preco             registered running total / latched price
//   liberar_produto          dispense pulse
//   devolver/valor_devolucao refund pulse + amount
//   ocupado                  transaction in progress
// ---------------------------------------------------------------------------
interface venda_if;
   logic       sel_valida;
   logic [1:0] sel_produto;
   logic       moeda_valida;
   logic [3:0] moeda_valor;
   logic       cancelar;
   logic [3:0] total;
   logic [3:0] preco;
   logic       liberar_produto;
   logic       devolver;
   logic [3:0] valor_devolucao;
   logic       ocupado;

   modport master (
      output sel_valida, sel_produto, moeda_valida, moeda_valor, cancelar,
      input  total, preco, liberar_produto, devolver, valor_devolucao, ocupado
   );

   modport slave (
      input  sel_valida, sel_produto, moeda_valida, moeda_valor, cancelar,
      output total, preco, liberar_produto, devolver, valor_devolucao, ocupado
   );
endinterface

// File: rtl/controlador_venda.sv
// ---------------------------------------------------------------------------
// controlador_venda: single-transaction vending sequencer.
//   select -> accumulate coins -> compare with price -> dispense or refund.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    venda_if.slave (strobes in; total/preco/pulses/ocupado out)
// Optional build macro TROCO_EN: overpayment dispenses and returns change
// (total - preco) in the same cycle instead of refunding the full total.
// All outputs are registered.
// ---------------------------------------------------------------------------
module controlador_venda #(
   parameter logic [3:0]  PRECO_0        = 4'd3,
   parameter logic [3:0]  PRECO_1        = 4'd5,
   parameter logic [3:0]  PRECO_2        = 4'd7,
   parameter logic [3:0]  PRECO_3        = 4'd10,
   parameter logic [15:0] TIMEOUT_CICLOS = 16'd50000
) (
   input  logic   clk,
   input  logic   rst_n,
   venda_if.slave bus
);

   typedef enum logic [2:0] {OCIOSO, COLETA, VERIFICA, ENTREGA, DEVOLVE} estado_t;

   localparam logic [15:0] CNT_MAX = TIMEOUT_CICLOS - 16'd1;

   estado_t     estado;
   logic [15:0] cnt;
   logic [3:0]  total_r, preco_r, valor_r;
   logic        liberar_r, devolver_r, ocupado_r;

   logic [4:0]  soma;
   logic [3:0]  soma_sat;
   logic [3:0]  preco_tab;

   // 5-bit sum so the carry tells us when to clamp at 15
   assign soma     = {1'b0, total_r} + {1'b0, bus.moeda_valor};
   assign soma_sat = soma[4] ? 4'hF : soma[3:0];

   always_comb begin
      preco_tab = PRECO_0;
      case (bus.sel_produto)
         2'd0: preco_tab = PRECO_0;
         2'd1: preco_tab = PRECO_1;
         2'd2: preco_tab = PRECO_2;
         2'd3: preco_tab = PRECO_3;
         default: preco_tab = PRECO_0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado     <= OCIOSO;
         cnt        <= '0;
         total_r    <= '0;
         preco_r    <= '0;
         valor_r    <= '0;
         liberar_r  <= 1'b0;
         devolver_r <= 1'b0;
         ocupado_r  <= 1'b0;
      end else begin
         // pulses and refund amount live for exactly one cycle
         liberar_r  <= 1'b0;
         devolver_r <= 1'b0;
         valor_r    <= '0;
         case (estado)
            OCIOSO: begin
               if (bus.sel_valida) begin
                  preco_r   <= preco_tab;
                  total_r   <= '0;
                  cnt       <= '0;
                  ocupado_r <= 1'b1;
                  estado    <= COLETA;
               end
            end
            COLETA: begin
               if (bus.cancelar) begin
                  devolver_r <= 1'b1;
                  valor_r    <= total_r;
                  estado     <= DEVOLVE;
               end else if (bus.moeda_valida && (bus.moeda_valor != 4'd0)) begin
                  total_r <= soma_sat;
                  cnt     <= '0;
                  estado  <= VERIFICA;
               end else if (cnt == CNT_MAX) begin
                  devolver_r <= 1'b1;
                  valor_r    <= total_r;
                  estado     <= DEVOLVE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            VERIFICA: begin
               // cnt was cleared by the coin, so a return to COLETA restarts the timeout
               if (total_r == preco_r) begin
                  liberar_r <= 1'b1;
                  estado    <= ENTREGA;
               end else if (total_r < preco_r) begin
                  estado <= COLETA;
               end else begin
`ifdef TROCO_EN
                  liberar_r  <= 1'b1;
                  devolver_r <= 1'b1;
                  valor_r    <= total_r - preco_r;
                  estado     <= ENTREGA;
`else
                  devolver_r <= 1'b1;
                  valor_r    <= total_r;
                  estado     <= DEVOLVE;
`endif
               end
            end
            ENTREGA, DEVOLVE: begin
               total_r   <= '0;
               preco_r   <= '0;
               cnt       <= '0;
               ocupado_r <= 1'b0;
               estado    <= OCIOSO;
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

   assign bus.total           = total_r;
   assign bus.preco           = preco_r;
   assign bus.liberar_produto = liberar_r;
   assign bus.devolver        = devolver_r;
   assign bus.valor_devolucao = valor_r;
   assign bus.ocupado         = ocupado_r;

endmodule

// File: tb/tb_controlador_venda.sv
// ---------------------------------------------------------------------------
// tb_controlador_venda: directed bench for controlador_venda with the
// timeout shortened to 20 cycles. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_controlador_venda;
   logic clk;
   logic rst_n;
   int   total_n;
   int   bad;

   venda_if bus ();

   controlador_venda #(.TIMEOUT_CICLOS(16'd20)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic selecionar(input logic [1:0] p);
      bus.sel_valida  = 1'b1;
      bus.sel_produto = p;
      step();
      bus.sel_valida  = 1'b0;
   endtask

   task automatic moeda(input logic [3:0] v);
      bus.moeda_valida = 1'b1;
      bus.moeda_valor  = v;
      step();
      bus.moeda_valida = 1'b0;
      bus.moeda_valor  = 4'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.sel_valida = 0; bus.sel_produto = 0; bus.moeda_valida = 0;
      bus.moeda_valor = 0; bus.cancelar = 0;
      #3;
      total_n++;
      if ({bus.total, bus.preco, bus.valor_devolucao, bus.liberar_produto, bus.devolver, bus.ocupado} !== 15'd0) begin
         bad++; $display("FAIL reset_outputs got total=%0d preco=%0d lib=%b dev=%b ocup=%b exp all 0",
                         bus.total, bus.preco, bus.liberar_produto, bus.devolver, bus.ocupado);
      end
      step(); step();
      rst_n = 1'b1;
      step();
      total_n++;
      if (bus.ocupado !== 1'b0) begin bad++; $display("FAIL reset_idle got ocupado=%b exp 0", bus.ocupado); end
   endtask

   task automatic test_compra_exata();
      selecionar(2'd1);
      total_n++;
      if (bus.preco !== 4'd5 || bus.ocupado !== 1'b1) begin
         bad++; $display("FAIL exata_sel got preco=%0d ocup=%b exp 5 1", bus.preco, bus.ocupado);
      end
      moeda(4'd2);
      total_n++;
      if (bus.total !== 4'd2) begin bad++; $display("FAIL exata_total2 got %0d exp 2", bus.total); end
      step();                        // VERIFICA -> COLETA
      moeda(4'd3);                   // edge N: total=5
      total_n++;
      if (bus.total !== 4'd5 || bus.liberar_produto !== 1'b0) begin
         bad++; $display("FAIL exata_total5 got total=%0d lib=%b exp 5 0", bus.total, bus.liberar_produto);
      end
      step();                        // pulse cycle
      total_n++;
      if (bus.liberar_produto !== 1'b1 || bus.devolver !== 1'b0) begin
         bad++; $display("FAIL exata_pulse got lib=%b dev=%b exp 1 0", bus.liberar_produto, bus.devolver);
      end
      step();
      total_n++;
      if (bus.liberar_produto !== 1'b0 || bus.devolver !== 1'b0 || bus.total !== 4'd0 ||
          bus.preco !== 4'd0 || bus.ocupado !== 1'b0) begin
         bad++; $display("FAIL exata_after got lib=%b dev=%b total=%0d preco=%0d ocup=%b exp 0 0 0 0 0",
                         bus.liberar_produto, bus.devolver, bus.total, bus.preco, bus.ocupado);
      end
   endtask

   task automatic test_sobrepagamento();
      selecionar(2'd0);
      moeda(4'd5);
      step();
`ifdef TROCO_EN
      total_n++;
      if (bus.liberar_produto !== 1'b1 || bus.devolver !== 1'b1 || bus.valor_devolucao !== 4'd2) begin
         bad++; $display("FAIL sobre_troco got lib=%b dev=%b valor=%0d exp 1 1 2",
                         bus.liberar_produto, bus.devolver, bus.valor_devolucao);
      end
`else
      total_n++;
      if (bus.liberar_produto !== 1'b0 || bus.devolver !== 1'b1 || bus.valor_devolucao !== 4'd5) begin
         bad++; $display("FAIL sobre_refund got lib=%b dev=%b valor=%0d exp 0 1 5",
                         bus.liberar_produto, bus.devolver, bus.valor_devolucao);
      end
`endif
      step();
      total_n++;
      if (bus.devolver !== 1'b0 || bus.valor_devolucao !== 4'd0 || bus.ocupado !== 1'b0) begin
         bad++; $display("FAIL sobre_after got dev=%b valor=%0d ocup=%b exp 0 0 0",
                         bus.devolver, bus.valor_devolucao, bus.ocupado);
      end
   endtask

   task automatic test_cancelar();
      selecionar(2'd3);
      moeda(4'd4); step();
      moeda(4'd4); step();
      total_n++;
      if (bus.total !== 4'd8) begin bad++; $display("FAIL cancel_total got %0d exp 8", bus.total); end
      bus.cancelar = 1'b1;
      step();
      bus.cancelar = 1'b0;
      total_n++;
      if (bus.devolver !== 1'b1 || bus.valor_devolucao !== 4'd8 || bus.ocupado !== 1'b1 ||
          bus.liberar_produto !== 1'b0) begin
         bad++; $display("FAIL cancel_pulse got dev=%b valor=%0d ocup=%b lib=%b exp 1 8 1 0",
                         bus.devolver, bus.valor_devolucao, bus.ocupado, bus.liberar_produto);
      end
      step();
      total_n++;
      if (bus.ocupado !== 1'b0 || bus.devolver !== 1'b0) begin
         bad++; $display("FAIL cancel_after got ocup=%b dev=%b exp 0 0", bus.ocupado, bus.devolver);
      end
   endtask

   task automatic test_timeout();
      int n;
      bit seen;
      selecionar(2'd2);
      moeda(4'd2);
      step();                        // back in COLETA, counter at 0
      n = 0; seen = 0;
      while (!seen && n < 60) begin
         step();
         n++;
         if (bus.devolver === 1'b1) seen = 1;
      end
      total_n++;
      if (!seen || n !== 20) begin
         bad++; $display("FAIL timeout_latency got seen=%0d cycles=%0d exp 1 20", seen, n);
      end
      total_n++;
      if (bus.valor_devolucao !== 4'd2) begin
         bad++; $display("FAIL timeout_valor got %0d exp 2", bus.valor_devolucao);
      end
      step();
      bus.cancelar = 1'b1;           // ignored while idle
      step();
      bus.cancelar = 1'b0;
      total_n++;
      if (bus.devolver !== 1'b0 || bus.ocupado !== 1'b0) begin
         bad++; $display("FAIL idle_cancel got dev=%b ocup=%b exp 0 0", bus.devolver, bus.ocupado);
      end
      moeda(4'd3);
      step();
      total_n++;
      if (bus.total !== 4'd0 || bus.ocupado !== 1'b0 || bus.devolver !== 1'b0) begin
         bad++; $display("FAIL idle_coin got total=%0d ocup=%b dev=%b exp 0 0 0",
                         bus.total, bus.ocupado, bus.devolver);
      end
   endtask

   task automatic test_saturacao();
      selecionar(2'd3);
      moeda(4'd0);                   // zero-value coin is ignored
      total_n++;
      if (bus.total !== 4'd0 || bus.ocupado !== 1'b1) begin
         bad++; $display("FAIL zero_coin got total=%0d ocup=%b exp 0 1", bus.total, bus.ocupado);
      end
      moeda(4'd9); step();
      selecionar(2'd1);              // selection locked during COLETA
      total_n++;
      if (bus.preco !== 4'd10 || bus.total !== 4'd9) begin
         bad++; $display("FAIL sel_locked got preco=%0d total=%0d exp 10 9", bus.preco, bus.total);
      end
      moeda(4'd15);
      total_n++;
      if (bus.total !== 4'd15) begin bad++; $display("FAIL sat_total got %0d exp 15", bus.total); end
      step();
`ifdef TROCO_EN
      total_n++;
      if (bus.liberar_produto !== 1'b1 || bus.devolver !== 1'b1 || bus.valor_devolucao !== 4'd5) begin
         bad++; $display("FAIL sat_troco got lib=%b dev=%b valor=%0d exp 1 1 5",
                         bus.liberar_produto, bus.devolver, bus.valor_devolucao);
      end
`else
      total_n++;
      if (bus.liberar_produto !== 1'b0 || bus.devolver !== 1'b1 || bus.valor_devolucao !== 4'd15) begin
         bad++; $display("FAIL sat_refund got lib=%b dev=%b valor=%0d exp 0 1 15",
                         bus.liberar_produto, bus.devolver, bus.valor_devolucao);
      end
`endif
      step();
   endtask

   task automatic test_reset_meio();
      bit stray;
      selecionar(2'd3);
      moeda(4'd4); step();
      total_n++;
      if (bus.total !== 4'd4 || bus.ocupado !== 1'b1) begin
         bad++; $display("FAIL mid_pre got total=%0d ocup=%b exp 4 1", bus.total, bus.ocupado);
      end
      #2 rst_n = 1'b0;
      #1;
      total_n++;
      if ({bus.total, bus.preco, bus.valor_devolucao, bus.liberar_produto, bus.devolver, bus.ocupado} !== 15'd0) begin
         bad++; $display("FAIL mid_async got total=%0d preco=%0d dev=%b ocup=%b exp all 0",
                         bus.total, bus.preco, bus.devolver, bus.ocupado);
      end
      step();
      rst_n = 1'b1;
      stray = 0;
      repeat (5) begin
         step();
         if (bus.devolver !== 1'b0 || bus.ocupado !== 1'b0 || bus.liberar_produto !== 1'b0) stray = 1;
      end
      total_n++;
      if (stray) begin bad++; $display("FAIL mid_release got stray activity=1 exp 0"); end
      // machine must be back in OCIOSO: a fresh exact purchase works
      selecionar(2'd0);
      moeda(4'd3);
      step();
      total_n++;
      if (bus.liberar_produto !== 1'b1 || bus.devolver !== 1'b0) begin
         bad++; $display("FAIL mid_recover got lib=%b dev=%b exp 1 0", bus.liberar_produto, bus.devolver);
      end
      step();
   endtask

   initial begin
      total_n = 0;
      bad     = 0;
      test_reset();
      test_compra_exata();
      test_sobrepagamento();
      test_cancelar();
      test_timeout();
      test_saturacao();
      test_reset_meio();
      $display("test done: total=%0d bad=%0d", total_n, bad);
      $finish;
   end

endmodule
